// File: rtl/age_reservation_station_pkg.sv
// ============================================================================
// Package : ooo_types
// Brief   : Shared out-of-order core types used by the reservation station.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package ooo_types;

    localparam int PHYS_REG_BITS  = 6;
    localparam int ROB_IDX_BITS   = 6;
    localparam int OPCODE_BITS    = 8;
    localparam int NUM_WB_DEFAULT = 3;

    typedef struct packed {
        logic [ROB_IDX_BITS-1:0]  rob_idx;
        logic [OPCODE_BITS-1:0]   opcode;
        logic [PHYS_REG_BITS-1:0] prd;
        logic [PHYS_REG_BITS-1:0] prs1;
        logic [PHYS_REG_BITS-1:0] prs2;
    } renamed_instr_t;

    typedef struct packed {
        renamed_instr_t instr;
        logic           prs1_ready;
        logic           prs2_ready;
    } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/priority_decoder.sv
// ============================================================================
// Module : priority_decoder
// Brief  : One-hot grant of the lowest-index set request bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_decoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             found_o
);

    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i] && !found_o) begin
                gnt_o[i] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_age_matrix.sv
// ============================================================================
// Module : rs_age_matrix
// Brief  : Age matrix selecting the oldest eligible entry; only built when
//          RS_AGE_ISSUE_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef RS_AGE_ISSUE_EN
module rs_age_matrix #(
    parameter int RS_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_en_i,
    input  logic [RS_SIZE-1:0] alloc_oh_i,
    input  logic [RS_SIZE-1:0] valid_i,
    input  logic [RS_SIZE-1:0] eligible_i,
    output logic [RS_SIZE-1:0] oldest_o
);

    // age_q[i][j] == 1 means entry i is older than entry j
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_d;
    logic                            blocked;

    always_comb begin
        age_d = age_q;
        if (alloc_en_i) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_oh_i[i]) begin
                    age_d[i] = '0;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        age_d[j][i] = valid_i[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        oldest_o = '0;
        blocked  = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                blocked = blocked | (eligible_i[j] & age_q[j][i]);
            end
            oldest_o[i] = eligible_i[i] & ~blocked;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/age_reservation_station.sv
// ============================================================================
// Module : age_reservation_station
// Brief  : Reservation station with wakeup bypass; issue order is oldest-first
//          when RS_AGE_ISSUE_EN is defined, lowest-index otherwise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module age_reservation_station
    import ooo_types::*;
#(
    parameter int RS_SIZE = 8,
    parameter int NUM_WB  = NUM_WB_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  dispatch_valid,
    input  renamed_instr_t                        dispatch_instr,
    input  logic                                  prs1_ready_in,
    input  logic                                  prs2_ready_in,
    output logic                                  dispatch_ready,
    output logic                                  issue_valid,
    output rs_entry_t                             issue_entry,
    input  logic                                  eu_ready,
    input  logic [NUM_WB-1:0]                     wb_en,
    input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0]  wb_prd,
    input  logic                                  flush,
    output logic [$clog2(RS_SIZE):0]              count
);

    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [RS_SIZE-1:0] rdy1_q, rdy1_d;
    logic [RS_SIZE-1:0] rdy2_q, rdy2_d;
    renamed_instr_t     instr_q [RS_SIZE];

    logic [RS_SIZE-1:0] free_slots;
    logic [RS_SIZE-1:0] alloc_oh;
    logic               alloc_found;
    logic [RS_SIZE-1:0] eligible;
    logic [RS_SIZE-1:0] issue_oh;
    logic [RS_SIZE-1:0] wake1, wake2;
    logic               disp_rdy1, disp_rdy2;
    logic               dispatch_fire;
    logic               issue_fire;

    // Free/full come from registered valid bits only, so a slot freed by
    // issue this cycle is not visible to dispatch until the next cycle.
    assign free_slots = ~valid_q;

    priority_decoder #(
        .WIDTH (RS_SIZE)
    ) u_free_sel (
        .req_i   (free_slots),
        .gnt_o   (alloc_oh),
        .found_o (alloc_found)
    );

    assign dispatch_ready = alloc_found;
    assign dispatch_fire  = dispatch_valid & dispatch_ready & ~flush;
    assign eligible       = valid_q & rdy1_q & rdy2_q;

    always_comb begin
        wake1     = '0;
        wake2     = '0;
        disp_rdy1 = prs1_ready_in;
        disp_rdy2 = prs2_ready_in;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_en[k]) begin
                if (wb_prd[k] == dispatch_instr.prs1) disp_rdy1 = 1'b1;
                if (wb_prd[k] == dispatch_instr.prs2) disp_rdy2 = 1'b1;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (wb_prd[k] == instr_q[i].prs1) wake1[i] = 1'b1;
                    if (wb_prd[k] == instr_q[i].prs2) wake2[i] = 1'b1;
                end
            end
        end
    end

`ifdef RS_AGE_ISSUE_EN
    rs_age_matrix #(
        .RS_SIZE (RS_SIZE)
    ) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en_i (dispatch_fire),
        .alloc_oh_i (alloc_oh),
        .valid_i    (valid_q),
        .eligible_i (eligible),
        .oldest_o   (issue_oh)
    );

    assign issue_valid = |eligible;
`else
    logic issue_found;

    priority_decoder #(
        .WIDTH (RS_SIZE)
    ) u_issue_sel (
        .req_i   (eligible),
        .gnt_o   (issue_oh),
        .found_o (issue_found)
    );

    assign issue_valid = issue_found;
`endif

    assign issue_fire = issue_valid & eu_ready;

    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_oh[i]) begin
                issue_entry.instr      = instr_q[i];
                issue_entry.prs1_ready = rdy1_q[i];
                issue_entry.prs2_ready = rdy2_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q | wake1;
        rdy2_d  = rdy2_q | wake2;
        if (issue_fire) begin
            valid_d = valid_d & ~issue_oh;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (dispatch_fire && alloc_oh[i]) begin
                valid_d[i] = 1'b1;
                rdy1_d[i]  = disp_rdy1;
                rdy2_d[i]  = disp_rdy2;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
        // Ready bits live only as long as their entry.
        rdy1_d = rdy1_d & valid_d;
        rdy2_d = rdy2_d & valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
        end
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_payload
        always_ff @(posedge clk) begin
            if (dispatch_fire && alloc_oh[g]) begin
                instr_q[g] <= dispatch_instr;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

endmodule

`default_nettype wire
